quad_step_decoder: RTL and testbench
====================================

# quad_step_decoder

Upstream front end for the up/down counter. Takes the two raw, asynchronous phase lines of a quadrature rotary encoder and synchronises and debounces each line. It decodes the Gray-code phase sequence into single-cycle `increment` / `decrement` strobes, which wire directly onto the counter's ports of the same name. Illegal phase jumps are flagged and never produce a step.

## Interface
Parameters:
- `FILTER_CYCLES`, default 4: consecutive cycles a synchronised line must differ from its filtered value before the filtered value updates. Legal range 1–255.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `enc_a`  in  1: raw encoder phase A, asynchronous.
- `enc_b`  in  1: raw encoder phase B, asynchronous.
- `clr_err`  in  1: synchronous clear of `err_flag`.
- `increment`  out  1: one-cycle strobe, one forward quarter-step.
- `decrement`  out  1: one-cycle strobe, one reverse quarter-step.
- `err_pulse`  out  1: one-cycle strobe on an illegal phase transition.
- `err_flag`  out  1: sticky error indicator.

## Operation
- Per channel: 2-flop synchroniser (`s1`→`s2`), a filter counter, and a filtered bit `f`.
- Filter counter rules:
  - Cleared whenever `s2 == f`.
  - Increments each cycle that `s2 != f`.
  - When it equals `FILTER_CYCLES-1` and `s2 != f` still holds: `f <= s2` and the counter clears.
- Phase `p = {f_a, f_b}`. `p_prev` holds the previous filtered phase.
- Forward order: 00→01→11→10→00. Each forward transition gives `increment`.
- Reverse order: 00→10→11→01→00. Each reverse transition gives `decrement`.
- Both bits changing in the same update is illegal. It gives `err_pulse`, no step, and sets `err_flag`.
- `increment`, `decrement` and `err_pulse` are mutually exclusive, registered, and high for exactly one cycle.
- `err_flag` set vs clear:
  - Set by an error event.
  - Cleared by `clr_err`.
  - If both occur in the same cycle, set wins.
- FSM states:
  - `S_FILL`: entered on reset. Counts 2 cycles while the synchroniser fills. No decode, all strobes 0. On exit, loads `f_a`, `f_b` and `p_prev` directly from `s2`, so the resting encoder position never produces a step or error.
  - `S_RUN`: decode active. Stays in `S_RUN` until reset.

## Timing
- Reset values:
  - All outputs 0.
  - Filter counters 0, `s1`/`s2`/`f`/`p_prev` 0.
  - FSM in `S_FILL`.
- Reset mid-operation: outputs are 0 from the first edge sampling `reset_n=0`, and pending filter counts are discarded. After release, `S_FILL` occupies 2 cycles.
- Latency: let edge k be the first edge sampling a new stable level into `s1`.
  - `s2` updates at k+1.
  - `f` updates at k+1+FILTER_CYCLES.
  - The strobe is high in the cycle following edge k+2+FILTER_CYCLES, i.e. FILTER_CYCLES+2 edges.
- Pulses shorter than FILTER_CYCLES cycles at `s2` are rejected entirely.
- Throughput: the filter limits step rate to at most one per FILTER_CYCLES cycles per channel. Back-to-back legal steps produce separate strobes with no merging.
- Channels filter independently, so A and B edges closer together than the filter window can appear simultaneous and are reported as errors.

## Structure
- Shared package `quad_pkg`:
  - `typedef enum logic {S_FILL, S_RUN} quad_state_t`.
  - Phase constants `PH_00`, `PH_01`, `PH_11`, `PH_10`.
  - `localparam SYNC_STAGES = 2`.
- Sub-module `quad_chan_filter` (synchroniser + filter counter + `f`), instantiated once per phase. Parameter `FILTER_CYCLES`. Counter width is `$clog2(FILTER_CYCLES+1)`.
- The top level holds the FSM, `p_prev`, decode and output registers.

## Test plan
All cases use `FILTER_CYCLES=4`.

- **Resting position at reset:** `reset_n` low 3 cycles with `enc_a=1`, `enc_b=1`, then release and hold 20 cycles → no strobes, `err_flag=0`.
- **Forward revolution:** from rest 00, apply 01, 11, 10, 00, each held 10 cycles → 4 `increment` strobes, each 6 edges after its input change; `decrement=0`.
- **Reverse revolution:** from rest 00, apply 10, 11, 01, 00 → 4 `decrement` strobes; `increment=0`.
- **Glitch rejection:** `enc_a` high for 3 cycles then back low → no strobe, and the filter counter returns to 0.
- **Illegal transition:** 00→11 in one cycle, held 10 cycles → one `err_pulse`, `err_flag=1` stays set; no step strobe. `clr_err` for 1 cycle → `err_flag=0`. Error and `clr_err` in the same cycle → `err_flag=1`.
- **Reset during filtering:** `enc_a` 0→1, then `reset_n` low at edge k+3 for 2 cycles → no strobe is ever emitted for that edge, and after release the block settles to phase 10 with no strobes.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Holds the FSM state type, phase codes and the Gray-order helper.
package quad_pkg;

  typedef enum logic {
    S_FILL,
    S_RUN
  } quad_state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam int SYNC_STAGES = 2;

  // Next phase in the forward rotation order.
  function automatic logic [1:0] fwd_next(
    input logic [1:0] ph
  );
    logic [1:0] nx;
    nx = PH_00;
    case (ph)
      PH_00:   nx = PH_01;
      PH_01:   nx = PH_11;
      PH_11:   nx = PH_10;
      default: nx = PH_00;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder phase line: 2-flop synchroniser, then a debounce counter.
// Ports: clk, reset_n, raw (async in), load (seed f), f (filtered), ld_val.
module quad_chan_filter
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic load,
  output logic f,
  output logic ld_val
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s2;

  assign s2     = sync[SYNC_STAGES-1];
  // Value s2 takes on this edge, used to seed f at end of fill.
  assign ld_val = sync[SYNC_STAGES-2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      cnt  <= '0;
      f    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      if (load) begin
        f   <= ld_val;
        cnt <= '0;
      end else if (s2 == f) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        f   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: debounce both phases, emit step strobes.
// Ports: enc_a/enc_b raw in, clr_err; increment/decrement/err_pulse/err_flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic clr_err,
  output logic increment,
  output logic decrement,
  output logic err_pulse,
  output logic err_flag
);

  quad_state_t state;
  quad_state_t state_n;
  logic        fill_cnt;
  logic        load;
  logic        f_a;
  logic        f_b;
  logic        ld_a;
  logic        ld_b;
  logic [1:0]  p;
  logic [1:0]  p_prev;
  logic        inc_n;
  logic        dec_n;
  logic        err_n;

  quad_chan_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (enc_a),
    .load   (load),
    .f      (f_a),
    .ld_val (ld_a)
  );

  quad_chan_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (enc_b),
    .load   (load),
    .f      (f_b),
    .ld_val (ld_b)
  );

  assign p = {f_a, f_b};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_FILL;
      fill_cnt <= 1'b0;
    end else begin
      state    <= state_n;
      fill_cnt <= (state == S_FILL) ? ~fill_cnt : 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      S_FILL: begin
        if (fill_cnt) begin
          state_n = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          (p == p_prev):            ;
          (p == (p_prev ^ 2'b11)):  err_n = 1'b1;
          (p == fwd_next(p_prev)):  inc_n = 1'b1;
          default:                  dec_n = 1'b1;
        endcase
      end
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_prev    <= PH_00;
      increment <= 1'b0;
      decrement <= 1'b0;
      err_pulse <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      p_prev    <= load ? {ld_a, ld_b} : p;
      increment <= inc_n;
      decrement <= dec_n;
      err_pulse <= err_n;
      if (err_n) begin
        err_flag <= 1'b1;
      end else if (clr_err) begin
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder (FILTER_CYCLES = 4).
// Table rows, directed corner sequences, then random stimulus vs a model.
module tb_quad_step_decoder;

  localparam int F = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic enc_a   = 1'b0;
  logic enc_b   = 1'b0;
  logic clr_err = 1'b0;
  logic increment;
  logic decrement;
  logic err_pulse;
  logic err_flag;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  quad_step_decoder #(
    .FILTER_CYCLES(F)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .clr_err  (clr_err),
    .increment(increment),
    .decrement(decrement),
    .err_pulse(err_pulse),
    .err_flag (err_flag)
  );

  // Reference model state: edge index since reset release,
  // history of the synchronised level per edge, filtered bits.
  int       n;
  bit       fa, fb, la, lb;
  bit       m_inc, m_dec, m_err, m_flag;
  bit       pend;
  bit [1:0] p_old, p_new;
  bit       s2a[$];
  bit       s2b[$];
  int       c_inc, c_dec, c_err;

  function automatic int gidx(bit [1:0] ph);
    case (ph)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Filtered level flips once the synchronised level has
  // disagreed with it for the last F cycles since fill ended.
  function automatic bit win(bit q[$], int nn, bit f);
    if (nn - F < 2) return 1'b0;
    for (int j = nn - F; j < nn; j++)
      if (q[j] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit na, nb;
    int d;
    if (!reset_n) begin
      n = 0;
      m_inc = 0; m_dec = 0; m_err = 0; m_flag = 0;
      pend = 0; fa = 0; fb = 0; la = 0; lb = 0;
      s2a.delete(); s2b.delete();
      s2a.push_back(1'b0); s2b.push_back(1'b0);
      return;
    end
    n++;
    m_inc = 0; m_dec = 0; m_err = 0;
    if (pend) begin
      d = (gidx(p_new) - gidx(p_old)) & 3;
      m_inc = (d == 1);
      m_dec = (d == 3);
      m_err = (d == 2);
    end
    pend = 0;
    if (m_err) m_flag = 1'b1;
    else if (clr_err) m_flag = 1'b0;
    if (n == 2) begin
      fa = la;
      fb = lb;
    end else if (n > 2) begin
      na = win(s2a, n, fa) ? !fa : fa;
      nb = win(s2b, n, fb) ? !fb : fb;
      if ({na, nb} != {fa, fb}) begin
        pend  = 1'b1;
        p_old = {fa, fb};
        p_new = {na, nb};
      end
      fa = na;
      fb = nb;
    end
    s2a.push_back(n == 1 ? 1'b0 : la);
    s2b.push_back(n == 1 ? 1'b0 : lb);
    la = enc_a;
    lb = enc_b;
  endtask

  task automatic chk(string nm, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chkn(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("increment", increment, m_inc);
    chk("decrement", decrement, m_dec);
    chk("err_pulse", err_pulse, m_err);
    chk("err_flag", err_flag, m_flag);
    c_inc += int'(increment);
    c_dec += int'(decrement);
    c_err += int'(err_pulse);
  endtask

  task automatic clr_counts();
    c_inc = 0;
    c_dec = 0;
    c_err = 0;
  endtask

  typedef struct {
    bit a;
    bit b;
    bit clr;
    int hold;
    int n_inc;
    int n_dec;
    int n_err;
    bit flag;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 10, 1, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 10, 1, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 10, 1, 0, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 10, 1, 0, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 10, 0, 1, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 10, 0, 1, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 10, 0, 1, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 10, 0, 1, 0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 10, 0, 0, 1, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b1,  1, 0, 0, 0, 1'b0};

    // Resting position 11 through reset.
    enc_a = 1'b1; enc_b = 1'b1; reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_increment", increment, 1'b0);
    chk("rst_err_flag", err_flag, 1'b0);
    chkn("rst_cnt_a", int'(dut.u_chan_a.cnt), 0);
    reset_n = 1'b1;
    clr_counts();
    repeat (20) tick();
    chkn("rest_inc", c_inc, 0);
    chkn("rest_dec", c_dec, 0);
    chkn("rest_err", c_err, 0);
    chk("rest_flag", err_flag, 1'b0);

    // Re-home at 00.
    enc_a = 1'b0; enc_b = 1'b0; reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();

    for (int i = 0; i < 10; i++) begin
      enc_a = tbl[i].a;
      enc_b = tbl[i].b;
      clr_err = tbl[i].clr;
      clr_counts();
      for (int h = 0; h < tbl[i].hold; h++) begin
        tick();
        clr_err = 1'b0;
      end
      chkn($sformatf("row%0d_inc", i), c_inc, tbl[i].n_inc);
      chkn($sformatf("row%0d_dec", i), c_dec, tbl[i].n_dec);
      chkn($sformatf("row%0d_err", i), c_err, tbl[i].n_err);
      chk($sformatf("row%0d_flag", i), err_flag, tbl[i].flag);
    end

    // Illegal 11->00 with clr_err on the very edge the error lands.
    enc_a = 1'b0; enc_b = 1'b0;
    clr_counts();
    repeat (6) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("same_cycle_pulse", err_pulse, 1'b1);
    repeat (4) tick();
    chkn("same_cycle_err", c_err, 1);
    chkn("same_cycle_inc", c_inc, 0);
    chk("same_cycle_flag", err_flag, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    chk("cleared_flag", err_flag, 1'b0);

    // Glitch on A one cycle shorter than the filter window.
    clr_counts();
    enc_a = 1'b1;
    repeat (3) tick();
    enc_a = 1'b0;
    repeat (10) tick();
    chkn("glitch_inc", c_inc, 0);
    chkn("glitch_dec", c_dec, 0);
    chkn("glitch_err", c_err, 0);
    chkn("glitch_cnt", int'(dut.u_chan_a.cnt), 0);

    // Reset lands while the A edge is still being filtered.
    clr_counts();
    enc_a = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chkn("rstf_inc", c_inc, 0);
    chkn("rstf_dec", c_dec, 0);
    chkn("rstf_err", c_err, 0);
    chk("rstf_fa", dut.u_chan_a.f, 1'b1);
    chk("rstf_fb", dut.u_chan_b.f, 1'b0);

    // Random stimulus against the model.
    for (int s = 0; s < 500; s++) begin
      enc_a = 1'($urandom_range(0, 1));
      enc_b = 1'($urandom_range(0, 1));
      clr_err = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 59) == 0) reset_n = 1'b0;
      for (int h = 0; h < int'($urandom_range(1, 12)); h++) begin
        tick();
        clr_err = 1'b0;
        reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
